multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the 64-bit RISC-V datapath. It replaces the single-cycle control unit's combinational decode with a state machine that spreads each instruction over 3–5+ cycles, so one ALU and one data memory port serve every phase. It decodes the instruction register's opcode/funct3 and drives all datapath enables and mux selects. It stalls on a data-memory ready handshake.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instruction register bits [6:0]
- funct3  in  3  instruction register bits [14:12]
- zero  in  1  ALU zero flag
- mem_ready  in  1  data memory completes the current access this cycle
- ir_write  out  1  latch instruction memory output into IR
- pc_write  out  1  update PC this cycle
- pc_src  out  1  0 = PC+4, 1 = PC + (imm<<1)
- alu_src_b  out  1  0 = rs2, 1 = imm
- alu_op  out  2  00 add, 01 branch-compare (sub), 10 funct-decoded
- mem_read  out  1  data memory read request
- mem_write  out  1  data memory write request
- mem_to_reg  out  1  writeback source: 1 = memory, 0 = ALU
- reg_write  out  1  register file write enable
- illegal  out  1  sticky: unsupported opcode decoded
- state  out  4  current state encoding, for debug
- cycle_count  out  64  cycles since reset (see Configuration)
- instret  out  64  retired instructions (see Configuration)

## Operation
- Supported opcodes: R 0110011, I-ALU 0010011, LD 0000011, SD 0100011, branch 1100011 (funct3 000 BEQ, 001 BNE).
- States and transitions:
  - FETCH: ir_write=1 → DECODE.
  - DECODE: the datapath latches the register operands. R/I → EXEC. LD/SD → MEM_ADDR. Branch → BRANCH. Any other opcode, or branch funct3 ∉ {000,001} → TRAP.
  - EXEC: alu_op=10; alu_src_b=0 for R, 1 for I → ALU_WB.
  - ALU_WB: reg_write=1, mem_to_reg=0, pc_write=1, pc_src=0 → FETCH.
  - MEM_ADDR: alu_op=00, alu_src_b=1 → MEM_RD (LD) or MEM_WR (SD).
  - MEM_RD: mem_read=1, held until mem_ready=1 → MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, pc_write=1, pc_src=0 → FETCH.
  - MEM_WR: mem_write=1, held until mem_ready. On the ready cycle: pc_write=1, pc_src=0 → FETCH.
  - BRANCH: alu_op=01, alu_src_b=0, pc_write=1. pc_src = zero for BEQ, !zero for BNE → FETCH.
  - TRAP: all enables 0, illegal=1. Stays in TRAP until rst.
- Outputs are Moore-decoded from state. Exceptions: pc_src in BRANCH, and pc_write in MEM_WR, are combinational on the inputs.
- Outside MEM_RD/MEM_WR, mem_ready is ignored.
- Every enable not listed for a state is 0.
- Unlisted selects are 0.

## Timing
- Reset: state=FETCH, illegal=0, cycle_count=0, instret=0. All enables are 0 except ir_write=1, because FETCH is decoded.
- rst dominates every state, including a pending memory wait. The access is abandoned and no write-back or PC update occurs.
- Latency with mem_ready high on the first cycle:
  - R/I: 4 cycles.
  - LD: 5 cycles.
  - SD: 4 cycles.
  - Branch: 3 cycles.
- Each wait cycle on mem_ready adds exactly one cycle.
- mem_read and mem_write are never asserted together.
- A request stays asserted and stable until the cycle mem_ready=1 is sampled; it deasserts the following cycle.
- pc_write is asserted exactly once per retired instruction, in the final cycle.

## Configuration
- MC_PERF_CNT_EN defined:
  - cycle_count increments every cycle when not in reset, including in TRAP.
  - instret increments in every cycle with pc_write=1.
  - Both are 64-bit and wrap modulo 2^64.
- MC_PERF_CNT_EN undefined: the counter logic is absent, and cycle_count and instret are tied to 0. The port list is unchanged.

## Structure
- Package mc_pkg holds:
  - state enum (4-bit, with fixed encodings used by the state output);
  - opcode constants;
  - alu_op encodings;
  - branch funct3 constants.
- One sub-module, mc_perf_counters (clk, rst, retire, cycle_count, instret). It is instantiated only under MC_PERF_CNT_EN.

## Test plan
- Reset mid-MEM_RD with mem_ready=0 → next cycle state=FETCH, and reg_write and pc_write stay 0 throughout.
- R-type add (opcode 0110011) → FETCH, DECODE, EXEC, ALU_WB. reg_write and pc_write are 1 only in cycle 4, with alu_src_b=0.
- LD with mem_ready held low 3 cycles, then high → mem_read high for 4 consecutive cycles; MEM_WB has reg_write=1, mem_to_reg=1; total 8 cycles.
- BEQ: zero=1 gives pc_src=1; BNE: zero=1 gives pc_src=0. Each asserts pc_write in cycle 3.
- Opcode 1111111 → TRAP after DECODE; illegal=1 and all enables 0 for 10+ cycles; rst returns to FETCH with illegal=0.
- With MC_PERF_CNT_EN: 3 back-to-back R-types → cycle_count=12, instret=3. Without the macro, both read 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RISC-V sequencer: state encodings,
// opcode/funct3 constants and ALU operation selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_ALU_WB   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_TRAP     = 4'd9
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/mc_perf_counters.sv
// Free-running cycle counter and retired-instruction counter, both 64-bit
// and wrapping; only built when MC_PERF_CNT_EN is defined.
module mc_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire,
  output logic [63:0] cycle_count,
  output logic [63:0] instret
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      instret     <= '0;
    end else begin
      cycle_count <= cycle_count + 64'd1;
      if (retire) instret <= instret + 64'd1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 64-bit RISC-V datapath. Optional
// performance counters are enabled with the MC_PERF_CNT_EN macro.
module multicycle_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [63:0] cycle_count,
  output logic [63:0] instret
);

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // NOTE: every output and the next state get a default before the case so
  // no path leaves them unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_R, OP_I:   state_d = S_EXEC;
          OP_LD, OP_SD: state_d = S_MEM_ADDR;
          OP_BR:        state_d = (funct3 == F3_BEQ || funct3 == F3_BNE) ? S_BRANCH : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        alu_op    = ALU_FUNCT;
        alu_src_b = (opcode == OP_I);
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_b = 1'b1;
        state_d   = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        // A store retires on the ready cycle itself, so pc_write follows the handshake.
        mem_write = 1'b1;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_op   = ALU_SUB;
        pc_write = 1'b1;
        pc_src   = (funct3 == F3_BNE) ? ~zero : zero;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

`ifdef MC_PERF_CNT_EN
  mc_perf_counters u_perf (
    .clk         (clk),
    .rst         (rst),
    .retire      (pc_write),
    .cycle_count (cycle_count),
    .instret     (instret)
  );
`else
  assign cycle_count = '0;
  assign instret     = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes hand-written
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        ir_write, pc_write, pc_src, alu_src_b;
  logic [1:0]  alu_op;
  logic        mem_read, mem_write, mem_to_reg, reg_write, illegal;
  logic [3:0]  state;
  logic [63:0] cycle_count, instret;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct3      (funct3),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .illegal     (illegal),
    .state       (state),
    .cycle_count (cycle_count),
    .instret     (instret)
  );

  typedef struct {
    string       name;
    logic [14:0] ctl;
    logic [63:0] cyc;
    logic [63:0] ret;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [63:0] exp_cyc, exp_ret;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Packed control vector: {state, ir_write, pc_write, pc_src, alu_src_b,
  // alu_op, mem_read, mem_write, mem_to_reg, reg_write, illegal}.
  function automatic logic [14:0] c(input logic [3:0] st, input logic irw, input logic pcw,
                                    input logic pcs, input logic asb, input logic [1:0] aop,
                                    input logic mr, input logic mw, input logic m2r,
                                    input logic rw, input logic ill);
    return {st, irw, pcw, pcs, asb, aop, mr, mw, m2r, rw, ill};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.name, ".ctl"}, {49'd0, state, ir_write, pc_write, pc_src, alu_src_b, alu_op,
                               mem_read, mem_write, mem_to_reg, reg_write, illegal}, {49'd0, e.ctl});
      check({e.name, ".cycle_count"}, cycle_count, e.cyc);
      check({e.name, ".instret"}, instret, e.ret);
    end
  end

  task automatic step(input string name, input logic [6:0] op, input logic [2:0] f3,
                      input logic z, input logic rdy, input logic r, input logic [14:0] ctl);
    exp_t e;
    opcode = op; funct3 = f3; zero = z; mem_ready = rdy; rst = r;
    e.name = name;
    e.ctl  = ctl;
`ifdef MC_PERF_CNT_EN
    e.cyc = exp_cyc;
    e.ret = exp_ret;
`else
    e.cyc = 64'd0;
    e.ret = 64'd0;
`endif
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (r) begin
      exp_cyc = 64'd0;
      exp_ret = 64'd0;
    end else begin
      exp_cyc = exp_cyc + 64'd1;
      if (ctl[9]) exp_ret = exp_ret + 64'd1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] v_fetch, v_dec, v_exec_r, v_exec_i, v_alu_wb, v_maddr, v_mrd, v_mwb;
    logic [14:0] v_mwr_wait, v_mwr_rdy, v_br0, v_br1, v_trap;
    v_fetch    = c(4'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    v_dec      = c(4'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    v_exec_r   = c(4'd2, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0);
    v_exec_i   = c(4'd2, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0);
    v_alu_wb   = c(4'd3, 0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    v_maddr    = c(4'd4, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0);
    v_mrd      = c(4'd5, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0);
    v_mwb      = c(4'd6, 0, 1, 0, 0, 2'b00, 0, 0, 1, 1, 0);
    v_mwr_wait = c(4'd7, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0);
    v_mwr_rdy  = c(4'd7, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0);
    v_br0      = c(4'd8, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0);
    v_br1      = c(4'd8, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0, 0);
    v_trap     = c(4'd9, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);

    rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; exp_cyc = 64'd0; exp_ret = 64'd0;

    // Three back-to-back R-types; the following fetch sees cycle_count=12, instret=3.
    for (int i = 0; i < 3; i++) begin
      step("r_fetch",  7'b0110011, 3'b000, 0, 1, 0, v_fetch);
      step("r_decode", 7'b0110011, 3'b000, 0, 1, 0, v_dec);
      step("r_exec",   7'b0110011, 3'b000, 0, 1, 0, v_exec_r);
      step("r_wb",     7'b0110011, 3'b000, 0, 1, 0, v_alu_wb);
    end

    step("i_fetch",  7'b0010011, 3'b000, 0, 0, 0, v_fetch);
    step("i_decode", 7'b0010011, 3'b000, 0, 0, 0, v_dec);
    step("i_exec",   7'b0010011, 3'b000, 0, 0, 0, v_exec_i);
    step("i_wb",     7'b0010011, 3'b000, 0, 0, 0, v_alu_wb);

    // Load with three wait cycles; mem_ready high before MEM_RD must be ignored.
    step("ld_fetch",  7'b0000011, 3'b011, 0, 1, 0, v_fetch);
    step("ld_decode", 7'b0000011, 3'b011, 0, 1, 0, v_dec);
    step("ld_addr",   7'b0000011, 3'b011, 0, 1, 0, v_maddr);
    step("ld_wait0",  7'b0000011, 3'b011, 0, 0, 0, v_mrd);
    step("ld_wait1",  7'b0000011, 3'b011, 0, 0, 0, v_mrd);
    step("ld_wait2",  7'b0000011, 3'b011, 0, 0, 0, v_mrd);
    step("ld_ready",  7'b0000011, 3'b011, 0, 1, 0, v_mrd);
    step("ld_wb",     7'b0000011, 3'b011, 0, 0, 0, v_mwb);

    step("sd_fetch",  7'b0100011, 3'b011, 0, 0, 0, v_fetch);
    step("sd_decode", 7'b0100011, 3'b011, 0, 0, 0, v_dec);
    step("sd_addr",   7'b0100011, 3'b011, 0, 0, 0, v_maddr);
    step("sd_wait",   7'b0100011, 3'b011, 0, 0, 0, v_mwr_wait);
    step("sd_ready",  7'b0100011, 3'b011, 0, 1, 0, v_mwr_rdy);

    step("beq_z1_fetch",  7'b1100011, 3'b000, 1, 0, 0, v_fetch);
    step("beq_z1_decode", 7'b1100011, 3'b000, 1, 0, 0, v_dec);
    step("beq_z1_br",     7'b1100011, 3'b000, 1, 0, 0, v_br1);
    step("beq_z0_fetch",  7'b1100011, 3'b000, 0, 0, 0, v_fetch);
    step("beq_z0_decode", 7'b1100011, 3'b000, 0, 0, 0, v_dec);
    step("beq_z0_br",     7'b1100011, 3'b000, 0, 0, 0, v_br0);
    step("bne_z1_fetch",  7'b1100011, 3'b001, 1, 0, 0, v_fetch);
    step("bne_z1_decode", 7'b1100011, 3'b001, 1, 0, 0, v_dec);
    step("bne_z1_br",     7'b1100011, 3'b001, 1, 0, 0, v_br0);
    step("bne_z0_fetch",  7'b1100011, 3'b001, 0, 0, 0, v_fetch);
    step("bne_z0_decode", 7'b1100011, 3'b001, 0, 0, 0, v_dec);
    step("bne_z0_br",     7'b1100011, 3'b001, 0, 0, 0, v_br1);

    // Unsupported opcode traps and stays trapped, ignoring mem_ready, until reset.
    step("bad_fetch",  7'b1111111, 3'b000, 0, 0, 0, v_fetch);
    step("bad_decode", 7'b1111111, 3'b000, 0, 0, 0, v_dec);
    for (int i = 0; i < 11; i++)
      step("bad_trap", 7'b1111111, 3'b000, 0, i[0], 0, v_trap);
    step("bad_trap_rst", 7'b1111111, 3'b000, 0, 0, 1, v_trap);
    step("after_trap_fetch", 7'b0110011, 3'b000, 0, 0, 0, v_fetch);

    // Branch with an unsupported funct3 also traps.
    step("bf3_decode", 7'b1100011, 3'b010, 0, 0, 0, v_dec);
    step("bf3_trap",   7'b1100011, 3'b010, 0, 0, 0, v_trap);
    step("bf3_rst",    7'b1100011, 3'b010, 0, 0, 1, v_trap);

    // Reset during a pending load wait abandons the access.
    step("rst_ld_fetch",  7'b0000011, 3'b011, 0, 0, 0, v_fetch);
    step("rst_ld_decode", 7'b0000011, 3'b011, 0, 0, 0, v_dec);
    step("rst_ld_addr",   7'b0000011, 3'b011, 0, 0, 0, v_maddr);
    step("rst_ld_wait",   7'b0000011, 3'b011, 0, 0, 0, v_mrd);
    step("rst_ld_rst",    7'b0000011, 3'b011, 0, 0, 1, v_mrd);
    step("rst_ld_fetch2", 7'b0000011, 3'b011, 0, 1, 0, v_fetch);
    step("rst_ld_decode2",7'b0000011, 3'b011, 0, 1, 0, v_dec);

    @(negedge clk); #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
